// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
// Two-port round-robin sequencer for the single-port data memory. Port A (CPU
// load/store) and port B (debug/DMA loader) each issue word requests. One
// request is granted at a time. The granted request drives the memory for
// exactly one ACCESS cycle. The read word is captured and returned with an ack.
//
// Optional build macro: ARB_STATS_EN
//   When defined, the outputs a_cnt, b_cnt and conflict_cnt (16 bit each) are
//   added. These are saturating grant and conflict counters.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   x_req/x_we/x_addr     request, store flag and byte address (x in {a,b})
//   x_wdata/x_pc          store data; PC that is forwarded to wPc
//   x_gnt                 1-cycle pulse during the ACCESS cycle of port x
//   x_ack                 1-cycle pulse in the cycle after ACCESS
//   x_rdata/x_err         load data and the illegal-access flag; held until the next ack
//   memAdr/memWrite       address and write strobe to mem
//   wdata/wPc             write data and PC to mem
//   memOut                combinational read of memAdr from mem
//   busy                  high while in ACCESS
// -----------------------------------------------------------------------------
module dm_arbiter #(
    parameter int unsigned       DATA_W  = 32,
    parameter logic [DATA_W-1:0] ADDR_LO = 32'h0000_0000,
    parameter logic [DATA_W-1:0] ADDR_HI = 32'h0000_2FFF
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [DATA_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic [DATA_W-1:0] a_pc,
    output logic              a_gnt,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_err,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [DATA_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    input  logic [DATA_W-1:0] b_pc,
    output logic              b_gnt,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err,

    output logic [DATA_W-1:0] memAdr,
    output logic              memWrite,
    output logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] wPc,
    input  logic [DATA_W-1:0] memOut,

    output logic              busy
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]       a_cnt,
    output logic [15:0]       b_cnt,
    output logic [15:0]       conflict_cnt
`endif
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t            state;
    state_t            stateNext;

    // ptrB: 1 = pointer on B, so A wins the next tie.
    logic              ptrB;
    logic              grantB;
    logic              latWe;
    logic [DATA_W-1:0] latAddr;
    logic [DATA_W-1:0] latWdata;
    logic [DATA_W-1:0] latPc;

    logic              anyReq;
    logic              bothReq;
    logic              pickB;
    logic              arbitrate;
    logic              addrLegal;
    logic [DATA_W-1:0] addrOffset;
    logic [DATA_W-1:0] loadData;

    assign anyReq    = a_req | b_req;
    assign bothReq   = a_req & b_req;
    // A single requester always wins; on a tie the port not pointed to wins.
    assign pickB     = b_req & (~a_req | ~ptrB);
    assign arbitrate = (state == IDLE) & anyReq;

    // Unsigned range check with one compare: offsets below ADDR_LO wrap to large values.
    assign addrOffset = latAddr - ADDR_LO;
    assign addrLegal  = (latAddr[1:0] == 2'b00) && (addrOffset <= (ADDR_HI - ADDR_LO));
    assign loadData   = (latWe || !addrLegal) ? '0 : memOut;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (anyReq) stateNext = ACCESS;
            ACCESS:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Memory-side outputs are driven only during the single ACCESS cycle.
    always_comb begin
        a_gnt    = 1'b0;
        b_gnt    = 1'b0;
        memAdr   = '0;
        memWrite = 1'b0;
        wdata    = '0;
        wPc      = '0;
        busy     = 1'b0;
        if (state == ACCESS) begin
            busy     = 1'b1;
            a_gnt    = ~grantB;
            b_gnt    = grantB;
            memAdr   = latAddr;
            memWrite = latWe & addrLegal;
            wdata    = latWdata;
            wPc      = latPc;
        end
    end

    // Request latch and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            ptrB     <= 1'b1;
            grantB   <= 1'b0;
            latWe    <= 1'b0;
            latAddr  <= '0;
            latWdata <= '0;
            latPc    <= '0;
        end else if (arbitrate) begin
            grantB   <= pickB;
            latWe    <= pickB ? b_we    : a_we;
            latAddr  <= pickB ? b_addr  : a_addr;
            latWdata <= pickB ? b_wdata : a_wdata;
            latPc    <= pickB ? b_pc    : a_pc;
            if (bothReq) begin
                ptrB <= pickB;
            end
        end
    end

    // Completion: ack pulse plus held read data and error flag per port.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_ack   <= 1'b0;
            b_ack   <= 1'b0;
            a_rdata <= '0;
            b_rdata <= '0;
            a_err   <= 1'b0;
            b_err   <= 1'b0;
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            if (state == ACCESS) begin
                if (grantB) begin
                    b_ack   <= 1'b1;
                    b_rdata <= loadData;
                    b_err   <= ~addrLegal;
                end else begin
                    a_ack   <= 1'b1;
                    a_rdata <= loadData;
                    a_err   <= ~addrLegal;
                end
            end
        end
    end

`ifdef ARB_STATS_EN
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Saturating grant and conflict counters
    always_ff @(posedge clk) begin
        if (reset) begin
            a_cnt        <= '0;
            b_cnt        <= '0;
            conflict_cnt <= '0;
        end else if (arbitrate) begin
            if (pickB) begin
                if (b_cnt != CNT_MAX) b_cnt <= b_cnt + 16'd1;
            end else begin
                if (a_cnt != CNT_MAX) a_cnt <= a_cnt + 16'd1;
            end
            if (bothReq && (conflict_cnt != CNT_MAX)) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
module tb_dm_arbiter;

    logic        clk;
    logic        reset;
    logic        a_req, a_we, b_req, b_we;
    logic [31:0] a_addr, a_wdata, a_pc, b_addr, b_wdata, b_pc;
    logic        a_gnt, a_ack, a_err, b_gnt, b_ack, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic [31:0] memAdr, wdata, wPc, memOut;
    logic        memWrite, busy;
`ifdef ARB_STATS_EN
    logic [15:0] a_cnt, b_cnt, conflict_cnt;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        isB;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    dm_arbiter dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_pc(a_pc),
        .a_gnt(a_gnt), .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_pc(b_pc),
        .b_gnt(b_gnt), .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
        .memAdr(memAdr), .memWrite(memWrite), .wdata(wdata), .wPc(wPc), .memOut(memOut),
        .busy(busy)
`ifdef ARB_STATS_EN
        , .a_cnt(a_cnt), .b_cnt(b_cnt), .conflict_cnt(conflict_cnt)
`endif
    );

    // Word memory model; clears on the same reset edge as the arbiter.
    logic [31:0] mem [0:4095];
    assign memOut = mem[memAdr[13:2]];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4096; i++) mem[i] <= '0;
        end else if (memWrite) begin
            mem[memAdr[13:2]] <= wdata;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        a_req = 1'b0; b_req = 1'b0;
        step();
        step();
        reset = 1'b0;
        sb.delete();
    endtask

    // Drives one request, waits for its grant, drops req, then steps into the ack cycle.
    task automatic access(input logic isB, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] pc,
                          output int lat, output logic mw, output logic [31:0] ma,
                          output logic [31:0] mwd, output logic [31:0] mpc,
                          output logic ack, output logic [31:0] rd, output logic er);
        if (isB) begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; b_pc = pc;
        end else begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; a_pc = pc;
        end
        lat = 0; mw = 1'b0; ma = '0; mwd = '0; mpc = '0;
        for (int i = 0; i < 8; i++) begin
            step();
            lat++;
            if ((isB ? b_gnt : a_gnt) === 1'b1) break;
        end
        if ((isB ? b_gnt : a_gnt) !== 1'b1) lat = 99;
        mw = memWrite; ma = memAdr; mwd = wdata; mpc = wPc;
        a_req = 1'b0; b_req = 1'b0;
        step();
        ack = isB ? b_ack : a_ack;
        rd  = isB ? b_rdata : a_rdata;
        er  = isB ? b_err : a_err;
    endtask

    task automatic test_reset();
        doReset();
        checks++;
        if ({a_gnt, a_ack, a_err, b_gnt, b_ack, b_err, memWrite, busy} !== 8'h00) begin
            failures++;
            $display("FAIL reset_flags: got %b want 00000000",
                     {a_gnt, a_ack, a_err, b_gnt, b_ack, b_err, memWrite, busy});
        end
        checks++;
        if ({memAdr, wdata, wPc, a_rdata, b_rdata} !== 160'h0) begin
            failures++;
            $display("FAIL reset_buses: memAdr=%h wdata=%h wPc=%h a_rdata=%h b_rdata=%h want 0",
                     memAdr, wdata, wPc, a_rdata, b_rdata);
        end
`ifdef ARB_STATS_EN
        checks++;
        if ({a_cnt, b_cnt, conflict_cnt} !== 48'h0) begin
            failures++;
            $display("FAIL reset_stats: got %h %h %h want 0", a_cnt, b_cnt, conflict_cnt);
        end
`endif
    endtask

    task automatic test_store_load();
        int lat; logic mw, ack, er; logic [31:0] ma, mwd, mpc, rd; exp_t e;
        doReset();
        sb.push_back('{1'b0, 32'd0, 1'b0});
        access(1'b0, 1'b1, 32'h0, 32'd7, 32'h3000, lat, mw, ma, mwd, mpc, ack, rd, er);
        checks++;
        if (lat !== 1) begin failures++; $display("FAIL store_latency: got %0d want 1", lat); end
        checks++;
        if ({mw, ma, mwd, mpc} !== {1'b1, 32'h0, 32'h7, 32'h3000}) begin
            failures++;
            $display("FAIL store_mem: memWrite=%b memAdr=%h wdata=%h wPc=%h want 1 0 7 3000", mw, ma, mwd, mpc);
        end
        checks++;
        if (ack === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            if (rd !== e.rdata || er !== e.err) begin
                failures++;
                $display("FAIL store_ack: rdata=%h err=%b want %h %b", rd, er, e.rdata, e.err);
            end
        end else begin
            failures++; $display("FAIL store_ack: ack=%b want 1", ack);
        end

        sb.push_back('{1'b0, 32'd7, 1'b0});
        access(1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'h3004, lat, mw, ma, mwd, mpc, ack, rd, er);
        checks++;
        if (mw !== 1'b0) begin failures++; $display("FAIL load_memwrite: got %b want 0", mw); end
        checks++;
        if (ack === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            if (rd !== e.rdata || er !== e.err) begin
                failures++;
                $display("FAIL load_ack: rdata=%h err=%b want %h %b", rd, er, e.rdata, e.err);
            end
        end else begin
            failures++; $display("FAIL load_ack: ack=%b want 1", ack);
        end
        step();
        checks++;
        if ({a_ack, a_rdata} !== {1'b0, 32'd7}) begin
            failures++; $display("FAIL rdata_hold: ack=%b rdata=%h want 0 7", a_ack, a_rdata);
        end
    endtask

    task automatic test_illegal();
        // addr, we, wdata, expected memWrite, expected rdata, expected err
        logic [31:0] tAddr [6] = '{32'h2, 32'h3000, 32'h0, 32'h3000, 32'h2FFC, 32'h2FFC};
        logic        tWe   [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] tWd   [6] = '{32'hDEAD, 32'hBEEF, 32'h0, 32'h0, 32'hA5, 32'h0};
        logic        tMw   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] tRd   [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hA5};
        logic        tErr  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        int lat; logic mw, ack, er; logic [31:0] ma, mwd, mpc, rd; exp_t e;
        doReset();
        for (int i = 0; i < 6; i++) begin
            sb.push_back('{1'b1, tRd[i], tErr[i]});
            access(1'b1, tWe[i], tAddr[i], tWd[i], 32'h100, lat, mw, ma, mwd, mpc, ack, rd, er);
            checks++;
            if (mw !== tMw[i] || lat !== 1) begin
                failures++;
                $display("FAIL illegal_mw[%0d]: memWrite=%b lat=%0d want %b 1", i, mw, lat, tMw[i]);
            end
            checks++;
            if (ack === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                if (rd !== e.rdata || er !== e.err) begin
                    failures++;
                    $display("FAIL illegal_ack[%0d]: rdata=%h err=%b want %h %b", i, rd, er, e.rdata, e.err);
                end
            end else begin
                failures++; $display("FAIL illegal_ack[%0d]: ack=%b want 1", i, ack);
            end
        end
    endtask

    task automatic test_conflict();
        exp_t e;
        logic expA, expB;
        doReset();
        a_we = 1'b0; a_addr = 32'h0; b_we = 1'b0; b_addr = 32'h4;
        a_req = 1'b1; b_req = 1'b1;
        sb.push_back('{1'b0, 32'h0, 1'b0});
        sb.push_back('{1'b1, 32'h0, 1'b0});
        sb.push_back('{1'b0, 32'h0, 1'b0});
        sb.push_back('{1'b1, 32'h0, 1'b0});
        for (int c = 1; c <= 8; c++) begin
            step();
            expA = ((c % 4) == 1);
            expB = ((c % 4) == 3);
            checks++;
            if ({a_gnt, b_gnt} !== {expA, expB}) begin
                failures++;
                $display("FAIL conflict_gnt[c%0d]: a_gnt=%b b_gnt=%b want %b %b", c, a_gnt, b_gnt, expA, expB);
            end
            if ((a_ack | b_ack) === 1'b1) begin
                checks++;
                if (sb.size() == 0 || (a_ack & b_ack) === 1'b1) begin
                    failures++; $display("FAIL conflict_ack[c%0d]: unexpected ack a=%b b=%b", c, a_ack, b_ack);
                end else begin
                    e = sb.pop_front();
                    if (b_ack !== e.isB || (e.isB ? b_rdata : a_rdata) !== e.rdata) begin
                        failures++;
                        $display("FAIL conflict_ack[c%0d]: b_ack=%b want port b=%b", c, b_ack, e.isB);
                    end
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL conflict_drain: %0d acks missing want 0", sb.size()); end
`ifdef ARB_STATS_EN
        checks++;
        if ({a_cnt, b_cnt, conflict_cnt} !== {16'd2, 16'd2, 16'd4}) begin
            failures++;
            $display("FAIL conflict_stats: got %0d %0d %0d want 2 2 4", a_cnt, b_cnt, conflict_cnt);
        end
`endif
        a_req = 1'b0; b_req = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset_abort();
        int lat; logic mw, ack, er; logic [31:0] ma, mwd, mpc, rd;
        doReset();
        // Tie won by A moves the pointer to A.
        a_we = 1'b0; a_addr = 32'h8; b_we = 1'b0; b_addr = 32'h8;
        a_req = 1'b1; b_req = 1'b1;
        step();
        a_req = 1'b0; b_req = 1'b0;
        step();
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'h4; a_wdata = 32'h55; a_pc = 32'h3010;
        step();
        checks++;
        if ({a_gnt, memWrite} !== 2'b11) begin
            failures++; $display("FAIL abort_pre: a_gnt=%b memWrite=%b want 1 1", a_gnt, memWrite);
        end
        reset = 1'b1; a_req = 1'b0;
        step();
        checks++;
        if ({a_ack, a_gnt, memWrite, busy, memAdr, wdata, wPc} !== 100'h0) begin
            failures++;
            $display("FAIL abort_outputs: ack=%b gnt=%b memWrite=%b busy=%b memAdr=%h want all 0",
                     a_ack, a_gnt, memWrite, busy, memAdr);
        end
        reset = 1'b0;
        step();
        checks++;
        if (a_ack !== 1'b0) begin failures++; $display("FAIL abort_late_ack: got %b want 0", a_ack); end
        // Pointer must be back on B, so A wins this tie.
        a_we = 1'b0; a_addr = 32'h8; b_we = 1'b0; b_addr = 32'h8;
        a_req = 1'b1; b_req = 1'b1;
        step();
        checks++;
        if ({a_gnt, b_gnt} !== 2'b10) begin
            failures++; $display("FAIL abort_pointer: a_gnt=%b b_gnt=%b want 1 0", a_gnt, b_gnt);
        end
        a_req = 1'b0; b_req = 1'b0;
        step();
        access(1'b0, 1'b0, 32'h4, 32'h0, 32'h3014, lat, mw, ma, mwd, mpc, ack, rd, er);
        checks++;
        if ({ack, rd, er} !== {1'b1, 32'h0, 1'b0}) begin
            failures++; $display("FAIL abort_load: ack=%b rdata=%h err=%b want 1 0 0", ack, rd, er);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic gntA [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic gntB [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        doReset();
        b_we = 1'b0; b_addr = 32'h8; b_req = 1'b1;
        sb.push_back('{1'b1, 32'h0, 1'b0});
        sb.push_back('{1'b0, 32'h0, 1'b0});
        sb.push_back('{1'b1, 32'h0, 1'b0});
        sb.push_back('{1'b1, 32'h0, 1'b0});
        for (int c = 1; c <= 8; c++) begin
            step();
            checks++;
            if ({a_gnt, b_gnt} !== {gntA[c-1], gntB[c-1]}) begin
                failures++;
                $display("FAIL stream_gnt[c%0d]: a_gnt=%b b_gnt=%b want %b %b", c, a_gnt, b_gnt, gntA[c-1], gntB[c-1]);
            end
            if ((a_ack | b_ack) === 1'b1) begin
                checks++;
                if (sb.size() == 0 || (a_ack & b_ack) === 1'b1) begin
                    failures++; $display("FAIL stream_ack[c%0d]: unexpected ack a=%b b=%b", c, a_ack, b_ack);
                end else begin
                    e = sb.pop_front();
                    if (b_ack !== e.isB) begin
                        failures++; $display("FAIL stream_ack[c%0d]: b_ack=%b want port b=%b", c, b_ack, e.isB);
                    end
                end
            end
            if (c == 2) begin a_we = 1'b0; a_addr = 32'hC; a_req = 1'b1; end
            if (c == 3) a_req = 1'b0;
        end
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL stream_drain: %0d acks missing want 0", sb.size()); end
`ifdef ARB_STATS_EN
        checks++;
        if ({a_cnt, b_cnt, conflict_cnt} !== {16'd1, 16'd3, 16'd1}) begin
            failures++;
            $display("FAIL stream_stats: got %0d %0d %0d want 1 3 1", a_cnt, b_cnt, conflict_cnt);
        end
`endif
        b_req = 1'b0;
        step();
        step();
    endtask

    initial begin
        reset = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_pc = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_pc = '0;
        test_reset();
        test_store_load();
        test_illegal();
        test_conflict();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
